ddr_axi_rd_checker: RTL and testbench
=====================================

// Module: ddr_axi_rd_checker
// PURPOSE
//  Passive checker on the AXI read channels between the read-traffic generator and the DDR3 controller port.
//  Snoops AR handshakes into a descriptor FIFO, then checks every R beat against an address-derived pattern.
//  Checks rid, rlast and rresp, counts errors and captures the first failure for LED and debug readout.
//  Requires in-order read return, which the controller port guarantees for this traffic.
// PARAMETERS
//  ADDR_WIDTH   32  AXI byte address width
//  DATA_WIDTH   64  AXI data width; fixed 64 (8-byte beats, arsize=3)
//  ID_WIDTH     8   AXI ID width
//  FIFO_DEPTH   4   outstanding-burst descriptors; power of 2
//  HALT_ON_ERR  0   1: freeze checking after first error
// PORTS
//  axi_clk     in   1           clock
//  top_rst_n   in   1           async active-low reset
//  clr         in   1           sync clear of counters, flags and capture
//  arvalid     in   1           snooped AR valid
//  arready     in   1           snooped AR ready
//  araddr      in   ADDR_WIDTH  snooped AR address
//  arlen       in   8           snooped AR length (beats-1)
//  arid        in   ID_WIDTH    snooped AR id
//  rvalid      in   1           snooped R valid
//  rready      in   1           snooped R ready
//  rdata       in   DATA_WIDTH  snooped R data
//  rid         in   ID_WIDTH    snooped R id
//  rresp       in   2           snooped R response
//  rlast       in   1           snooped R last
//  err_flag    out  1           sticky: any error since reset/clr
//  err_cnt     out  16          errored beats, saturates at 16'hFFFF
//  beat_cnt    out  32          checked beats, wraps
//  ovf_flag    out  1           sticky: AR accepted while FIFO full
//  fail_addr   out  ADDR_WIDTH  beat address of first error
//  fail_data   out  DATA_WIDTH  rdata of first error
//  busy        out  1           FIFO non-empty or burst in progress
// BEHAVIOUR
//  Reset (top_rst_n=0) and clr: all outputs 0, FIFO empty, beat index 0, state IDLE.
//  Push: arvalid&arready pushes {araddr,arlen,arid}; if FIFO full, descriptor dropped and ovf_flag set.
//  Beat: rvalid&rready. Beat address A = head.araddr + 8*idx (mod 2^ADDR_WIDTH, wraps).
//  Expected rdata = {A[31:0]^32'hA5A5_A5A5, A[31:0]}.
//  Beat errors, ORed: data mismatch; rid!=head.arid; rlast!=(idx==head.arlen); rresp!=2'b00.
//  Orphan beat (FIFO empty) counts as an error with A=0.
//  Pop: beat with idx==head.arlen (or rlast), then idx<=0; else idx<=idx+1.
//  Push and pop in the same cycle: both take effect; count unchanged.
//  Push into an empty FIFO makes the head visible the next cycle; a beat is never checked in the same cycle as its own AR.
//  Latency: beat_cnt, err_cnt, err_flag and fail_* update 1 cycle after the beat handshake.
//  fail_addr/fail_data load only when err_flag is 0 (first error).
//  FSM: IDLE (FIFO empty) -> ACTIVE on push; ACTIVE -> IDLE on pop with FIFO left empty and no push.
//  FSM: ACTIVE -> HALT on error if HALT_ON_ERR=1; HALT exits only via clr or reset.
//  In HALT, counters are frozen and pushes/pops are ignored.
//  clr together with a beat: clr wins and the beat is not counted.
//  Async reset mid-burst: all state discarded, with no spurious error afterwards.
//  busy = (state!=IDLE) | FIFO non-empty.
// TESTING
//  1. AR addr=0x100,len=3; 4 correct beats, rlast on beat 3 -> beat_cnt=4, err_cnt=0, err_flag=0, busy=0.
//  2. Same burst, beat 2 rdata bit0 flipped -> err_cnt=1, fail_addr=0x110, err_flag=1 one cycle after the beat.
//  3. 5 ARs back-to-back with no R beats (DEPTH=4) -> ovf_flag=1; 4 bursts then check clean.
//  4. R beat with FIFO empty -> err_cnt=1, fail_addr=0.
//  5. rresp=2'b10 or rid mismatch on a correct-data beat -> err_cnt+1; premature rlast -> error.
//  6. HALT_ON_ERR=1, error then 10 good beats -> counters frozen; clr -> all 0, then normal checking.

Source files
------------

// File: rtl/ddr_axi_rd_checker.sv
// ddr_axi_rd_checker: passive AXI read-channel checker.
// Snoops AR handshakes into a small descriptor FIFO and checks each R beat
// against the address-derived pattern {A[31:0]^32'hA5A5_A5A5, A[31:0]},
// along with rid, rlast and rresp. Read data must return in order.
//
// Handshake rule: an AR is taken only when arvalid && arready are both high
// on a rising axi_clk edge, and an R beat only when rvalid && rready are both
// high; valid without ready, or ready without valid, is never a transfer.
module ddr_axi_rd_checker #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int ID_WIDTH    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HALT_ON_ERR = 0
) (
    input  logic                  axi_clk,
    input  logic                  top_rst_n,
    input  logic                  clr,
    input  logic                  arvalid,
    input  logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic                  rvalid,
    input  logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  err_flag,
    output logic [15:0]           err_cnt,
    output logic [31:0]           beat_cnt,
    output logic                  ovf_flag,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int  PW        = $clog2(FIFO_DEPTH);
    localparam int  CW        = PW + 1;
    localparam bit  HALT_MODE = (HALT_ON_ERR != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]            fifo_len  [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id   [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [7:0]            idx;

    logic                  halted, ar_hs, r_hs, push, pop, ovf_evt;
    logic                  fifo_empty, fifo_full, last_beat, beat_err;
    logic [ADDR_WIDTH-1:0] head_addr, beat_addr;
    logic [7:0]            head_len;
    logic [ID_WIDTH-1:0]   head_id;
    logic [DATA_WIDTH-1:0] exp_data;

    // Handshake decode, head-of-FIFO beat check and error detection.
    always_comb begin
        halted     = (state == ST_HALT);
        ar_hs      = arvalid & arready & ~halted;
        r_hs       = rvalid & rready & ~halted;
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(FIFO_DEPTH));
        push       = ar_hs & ~fifo_full;
        ovf_evt    = ar_hs & fifo_full;
        head_addr  = fifo_addr[rd_ptr];
        head_len   = fifo_len[rd_ptr];
        head_id    = fifo_id[rd_ptr];
        // Orphan beats are reported against address 0.
        beat_addr  = fifo_empty ? '0 : head_addr + ADDR_WIDTH'({idx, 3'b000});
        exp_data   = {beat_addr[31:0] ^ 32'hA5A5_A5A5, beat_addr[31:0]};
        last_beat  = (idx == head_len) | rlast;
        pop        = r_hs & ~fifo_empty & last_beat;
        beat_err   = r_hs & (fifo_empty
                           | (rdata != exp_data)
                           | (rid != head_id)
                           | (rlast != (idx == head_len))
                           | (rresp != 2'b00));
    end

    // Next-state logic: ACTIVE while descriptors are queued, HALT is sticky.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (beat_err && HALT_MODE) state_nxt = ST_HALT;
                else if (push)             state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (beat_err && HALT_MODE)                       state_nxt = ST_HALT;
                else if (pop && (count == CW'(1)) && !push)      state_nxt = ST_IDLE;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Descriptor storage; contents are only meaningful between the pointers.
    always_ff @(posedge axi_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= araddr;
            fifo_len[wr_ptr]  <= arlen;
            fifo_id[wr_ptr]   <= arid;
        end
    end

    // State, FIFO pointers, beat index, counters and first-failure capture.
    always_ff @(posedge axi_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            idx       <= '0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            beat_cnt  <= '0;
            ovf_flag  <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clr) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            idx       <= '0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            beat_cnt  <= '0;
            ovf_flag  <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop)                    idx <= '0;
            else if (r_hs && !fifo_empty) idx <= idx + 8'd1;
            if (ovf_evt) ovf_flag <= 1'b1;
            if (r_hs)    beat_cnt <= beat_cnt + 32'd1;
            if (beat_err) begin
                err_flag <= 1'b1;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (!err_flag) begin
                    fail_addr <= beat_addr;
                    fail_data <= rdata;
                end
            end
        end
    end

    assign busy      = (state != ST_IDLE) | (count != '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_ddr_axi_rd_checker.sv
// tb_ddr_axi_rd_checker: directed test of ddr_axi_rd_checker.
// Two instances share all stimulus except clr: u_norm (HALT_ON_ERR=0) and
// u_halt (HALT_ON_ERR=1). Expected values are hand-computed per vector.
module tb_ddr_axi_rd_checker;

    logic        axi_clk = 1'b0;
    logic        top_rst_n;
    logic        clr_n, clr_h;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen, arid;
    logic        rvalid, rready;
    logic [63:0] rdata;
    logic [7:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;

    logic        n_err_flag, n_ovf_flag, n_busy;
    logic [15:0] n_err_cnt;
    logic [31:0] n_beat_cnt, n_fail_addr;
    logic [63:0] n_fail_data;
    logic [1:0]  n_state;
    logic        h_err_flag, h_ovf_flag, h_busy;
    logic [15:0] h_err_cnt;
    logic [31:0] h_beat_cnt, h_fail_addr;
    logic [63:0] h_fail_data;
    logic [1:0]  h_state;

    int n_vec  = 0;
    int n_miss = 0;

    // Clock / reset
    always #5 axi_clk = ~axi_clk;

    ddr_axi_rd_checker #(.HALT_ON_ERR(0)) u_norm (
        .axi_clk(axi_clk), .top_rst_n(top_rst_n), .clr(clr_n),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .err_flag(n_err_flag), .err_cnt(n_err_cnt), .beat_cnt(n_beat_cnt), .ovf_flag(n_ovf_flag),
        .fail_addr(n_fail_addr), .fail_data(n_fail_data), .busy(n_busy), .dbg_state(n_state)
    );

    ddr_axi_rd_checker #(.HALT_ON_ERR(1)) u_halt (
        .axi_clk(axi_clk), .top_rst_n(top_rst_n), .clr(clr_h),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .err_flag(h_err_flag), .err_cnt(h_err_cnt), .beat_cnt(h_beat_cnt), .ovf_flag(h_ovf_flag),
        .fail_addr(h_fail_addr), .fail_data(h_fail_data), .busy(h_busy), .dbg_state(h_state)
    );

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_A5A5, a};
    endfunction

    // Scoreboard compare
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers: inputs change on the falling edge, outputs are read there too.
    task automatic ar_push(input logic [31:0] a, input logic [7:0] len, input logic [7:0] id);
        arvalid = 1'b1; arready = 1'b1; araddr = a; arlen = len; arid = id;
        @(negedge axi_clk);
        arvalid = 1'b0; arready = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] d, input logic [7:0] id,
                          input logic [1:0] resp, input logic last);
        rvalid = 1'b1; rready = 1'b1; rdata = d; rid = id; rresp = resp; rlast = last;
        @(negedge axi_clk);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    task automatic good_burst(input logic [31:0] a, input logic [7:0] len, input logic [7:0] id);
        ar_push(a, len, id);
        for (int i = 0; i <= int'(len); i++)
            r_beat(pat(a + 32'(8 * i)), id, 2'b00, i == int'(len));
    endtask

    task automatic pulse_clr(input logic do_n, input logic do_h);
        clr_n = do_n; clr_h = do_h;
        @(negedge axi_clk);
        clr_n = 1'b0; clr_h = 1'b0;
    endtask

    initial begin
        top_rst_n = 1'b0; clr_n = 1'b0; clr_h = 1'b0;
        arvalid = 1'b0; arready = 1'b0; araddr = '0; arlen = '0; arid = '0;
        rvalid = 1'b0; rready = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
        repeat (3) @(negedge axi_clk);

        // Reset state
        check_val("rst_err_flag", 64'(n_err_flag), 64'd0);
        check_val("rst_err_cnt",  64'(n_err_cnt),  64'd0);
        check_val("rst_beat_cnt", 64'(n_beat_cnt), 64'd0);
        check_val("rst_ovf",      64'(n_ovf_flag), 64'd0);
        check_val("rst_busy",     64'(n_busy),     64'd0);
        check_val("rst_state",    64'(n_state),    64'd0);
        top_rst_n = 1'b1;
        @(negedge axi_clk);

        // 1: clean 4-beat burst, plus a valid-without-ready cycle that must not count
        ar_push(32'h100, 8'd3, 8'd1);
        check_val("t1_busy_mid", 64'(n_busy), 64'd1);
        r_beat(pat(32'h100), 8'd1, 2'b00, 1'b0);
        r_beat(pat(32'h108), 8'd1, 2'b00, 1'b0);
        rvalid = 1'b1; rdata = 64'hDEAD; @(negedge axi_clk); rvalid = 1'b0;
        r_beat(pat(32'h110), 8'd1, 2'b00, 1'b0);
        r_beat(pat(32'h118), 8'd1, 2'b00, 1'b1);
        check_val("t1_beat_cnt", 64'(n_beat_cnt), 64'd4);
        check_val("t1_err_cnt",  64'(n_err_cnt),  64'd0);
        check_val("t1_err_flag", 64'(n_err_flag), 64'd0);
        check_val("t1_busy",     64'(n_busy),     64'd0);
        check_val("t1_h_beat",   64'(h_beat_cnt), 64'd4);

        // 2: bit 0 of beat 2 flipped
        ar_push(32'h100, 8'd3, 8'd1);
        r_beat(pat(32'h100), 8'd1, 2'b00, 1'b0);
        r_beat(pat(32'h108), 8'd1, 2'b00, 1'b0);
        check_val("t2_flag_before", 64'(n_err_flag), 64'd0);
        r_beat(pat(32'h110) ^ 64'd1, 8'd1, 2'b00, 1'b0);
        check_val("t2_err_flag",  64'(n_err_flag),  64'd1);
        check_val("t2_err_cnt",   64'(n_err_cnt),   64'd1);
        check_val("t2_fail_addr", 64'(n_fail_addr), 64'h110);
        check_val("t2_fail_data", n_fail_data,      pat(32'h110) ^ 64'd1);
        check_val("t2_h_state",   64'(h_state),     64'd2);
        r_beat(pat(32'h118), 8'd1, 2'b00, 1'b1);
        check_val("t2_beat_cnt",  64'(n_beat_cnt),  64'd8);
        check_val("t2_err_cnt_end", 64'(n_err_cnt), 64'd1);
        check_val("t2_busy",      64'(n_busy),      64'd0);
        check_val("t2_h_beat",    64'(h_beat_cnt),  64'd7);
        check_val("t2_h_fail",    64'(h_fail_addr), 64'h110);

        // 3: five ARs into a 4-deep FIFO, then the four kept bursts check clean
        pulse_clr(1'b1, 1'b0);
        check_val("t3_clr_err",  64'(n_err_flag), 64'd0);
        check_val("t3_clr_beat", 64'(n_beat_cnt), 64'd0);
        for (int k = 1; k <= 5; k++) ar_push(32'(k * 32'h1000), 8'd1, 8'(2 + k));
        check_val("t3_ovf",   64'(n_ovf_flag), 64'd1);
        check_val("t3_busy1", 64'(n_busy),     64'd1);
        for (int k = 1; k <= 4; k++) begin
            r_beat(pat(32'(k * 32'h1000)),     8'(2 + k), 2'b00, 1'b0);
            r_beat(pat(32'(k * 32'h1000) + 8), 8'(2 + k), 2'b00, 1'b1);
        end
        check_val("t3_err_cnt",  64'(n_err_cnt),  64'd0);
        check_val("t3_beat_cnt", 64'(n_beat_cnt), 64'd8);
        check_val("t3_busy0",    64'(n_busy),     64'd0);
        check_val("t3_h_ovf",    64'(h_ovf_flag), 64'd0);

        // 4: orphan beat
        pulse_clr(1'b1, 1'b0);
        r_beat(64'h1234_5678_9ABC_DEF0, 8'd0, 2'b00, 1'b1);
        check_val("t4_err_cnt",   64'(n_err_cnt),   64'd1);
        check_val("t4_err_flag",  64'(n_err_flag),  64'd1);
        check_val("t4_fail_addr", 64'(n_fail_addr), 64'd0);
        check_val("t4_fail_data", n_fail_data,      64'h1234_5678_9ABC_DEF0);
        check_val("t4_beat_cnt",  64'(n_beat_cnt),  64'd1);

        // 5: bad rresp, bad rid, premature rlast on correct-data beats
        pulse_clr(1'b1, 1'b0);
        ar_push(32'h40, 8'd3, 8'd9);
        r_beat(pat(32'h40), 8'd9, 2'b10, 1'b0);
        check_val("t5_resp_err", 64'(n_err_cnt), 64'd1);
        r_beat(pat(32'h48), 8'd8, 2'b00, 1'b0);
        check_val("t5_rid_err",  64'(n_err_cnt), 64'd2);
        r_beat(pat(32'h50), 8'd9, 2'b00, 1'b1);
        check_val("t5_rlast_err", 64'(n_err_cnt),  64'd3);
        check_val("t5_fail_addr", 64'(n_fail_addr), 64'h40);
        check_val("t5_busy",      64'(n_busy),      64'd0);
        check_val("t5_beat_cnt",  64'(n_beat_cnt),  64'd3);
        // clr in the same cycle as a beat: the beat is not counted
        clr_n = 1'b1;
        r_beat(64'hBAD, 8'd0, 2'b00, 1'b1);
        clr_n = 1'b0;
        check_val("t5_clr_beat", 64'(n_beat_cnt), 64'd0);
        check_val("t5_clr_err",  64'(n_err_flag), 64'd0);

        // 6: HALT_ON_ERR=1 instance stayed frozen, then error + 10 good beats
        check_val("t6_h_frozen_beat", 64'(h_beat_cnt), 64'd7);
        check_val("t6_h_frozen_err",  64'(h_err_cnt),  64'd1);
        check_val("t6_h_busy",        64'(h_busy),     64'd1);
        pulse_clr(1'b1, 1'b1);
        check_val("t6_h_clr_state", 64'(h_state),    64'd0);
        check_val("t6_h_clr_beat",  64'(h_beat_cnt), 64'd0);
        check_val("t6_h_clr_err",   64'(h_err_flag), 64'd0);
        ar_push(32'h300, 8'd10, 8'd2);
        for (int i = 0; i <= 10; i++)
            r_beat(pat(32'h300 + 32'(8 * i)), 8'd2, (i == 0) ? 2'b10 : 2'b00, i == 10);
        check_val("t6_h_beat",  64'(h_beat_cnt),  64'd1);
        check_val("t6_h_err",   64'(h_err_cnt),   64'd1);
        check_val("t6_h_fail",  64'(h_fail_addr), 64'h300);
        check_val("t6_h_state", 64'(h_state),     64'd2);
        check_val("t6_n_beat",  64'(n_beat_cnt),  64'd11);
        check_val("t6_n_err",   64'(n_err_cnt),   64'd1);
        pulse_clr(1'b0, 1'b1);
        check_val("t6_h_clr2_busy", 64'(h_busy),    64'd0);
        check_val("t6_h_clr2_err",  64'(h_err_cnt), 64'd0);
        good_burst(32'h700, 8'd1, 8'd4);
        check_val("t6_h_after_beat", 64'(h_beat_cnt), 64'd2);
        check_val("t6_h_after_err",  64'(h_err_cnt),  64'd0);

        // 7: async reset mid-burst, then a clean burst
        ar_push(32'h500, 8'd3, 8'd1);
        r_beat(pat(32'h500), 8'd1, 2'b00, 1'b0);
        r_beat(pat(32'h508), 8'd1, 2'b00, 1'b0);
        #2 top_rst_n = 1'b0;
        #1;
        check_val("t7_rst_busy", 64'(n_busy),     64'd0);
        check_val("t7_rst_beat", 64'(n_beat_cnt), 64'd0);
        @(negedge axi_clk);
        top_rst_n = 1'b1;
        @(negedge axi_clk);
        good_burst(32'h600, 8'd1, 8'd2);
        check_val("t7_n_err",  64'(n_err_cnt),  64'd0);
        check_val("t7_n_beat", 64'(n_beat_cnt), 64'd2);
        check_val("t7_h_err",  64'(h_err_flag), 64'd0);
        check_val("t7_n_busy", 64'(n_busy),     64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
